mp_add_seq: RTL and testbench

Multi-precision sequential adder controller. It computes W = N*K-bit sums by time-multiplexing a single N-bit ripple-carry adder slice over K cycles, with a registered carry between chunks. Operands arrive on a valid/ready input handshake and the result leaves on a valid/ready output handshake. It sits between wide-operand producers (accumulators, address generators) and consumers that can tolerate multi-cycle latency in exchange for the area of one narrow adder.

---
 rtl/mp_add_pkg.sv | 16 +
 rtl/mp_add_seq_if.sv | 37 +++
 rtl/n_adder.sv | 16 +
 rtl/mp_add_seq.sv | 111 +++++++++++
 tb/tb_mp_add_seq.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mp_add_pkg.sv
// mp_add_pkg: shared types and defaults for the multi-precision sequential adder.
//   state_t : controller states (IDLE, RUN, DONE)
//   N_DEF   : default chunk width (width of the shared adder slice)
//   K_DEF   : default number of chunks per operation
package mp_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_DEF = 8;
    localparam int K_DEF = 4;

endpackage

// File: rtl/mp_add_seq_if.sv
// mp_add_seq_if: operand/result handshake bundle for mp_add_seq.
//   in_valid/in_ready   : operand handshake (a, b, c_in, and sub when MP_ADD_SUB_EN)
//   out_valid/out_ready : result handshake (sum, c_out)
//   master modport      : producer/consumer side; slave modport: the adder.
// Optional feature macro: MP_ADD_SUB_EN adds the sub request line.
interface mp_add_seq_if #(
    parameter int N = 8,
    parameter int K = 4
) ();
    localparam int W = N * K;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
`ifdef MP_ADD_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;

`ifdef MP_ADD_SUB_EN
    modport master (output in_valid, a, b, c_in, sub, out_ready,
                    input  in_ready, out_valid, sum, c_out);
    modport slave  (input  in_valid, a, b, c_in, sub, out_ready,
                    output in_ready, out_valid, sum, c_out);
`else
    modport master (output in_valid, a, b, c_in, out_ready,
                    input  in_ready, out_valid, sum, c_out);
    modport slave  (input  in_valid, a, b, c_in, out_ready,
                    output in_ready, out_valid, sum, c_out);
`endif

endinterface

// File: rtl/n_adder.sv
// n_adder: N-bit adder slice with carry in/out, shared across all chunks.
//   a, b : N-bit chunk operands
//   ci   : carry into the slice
//   s    : N-bit chunk sum
//   co   : carry out of the slice
module n_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
endmodule

// File: rtl/mp_add_seq.sv
// mp_add_seq: W = N*K bit adder built from one N-bit slice used over K cycles.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : mp_add_seq_if.slave -- operand handshake in, result handshake out
// Optional feature macro: MP_ADD_SUB_EN (subtract via b inversion and carry-in 1).
// Latency from input handshake to out_valid is K+1 cycles; in_ready/out_valid
// are registered so no input reaches an output combinationally.
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int K = K_DEF
) (
    input  logic         clk,
    input  logic         rst,
    mp_add_seq_if.slave  bus
);
    localparam int W  = N * K;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  a_sh_q, a_sh_d;
    logic [W-1:0]  b_sh_q, b_sh_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;

    logic [N-1:0]  slice_s;
    logic          slice_co;

    n_adder #(.N(N)) u_slice (
        .a  (a_sh_q[N-1:0]),
        .b  (b_sh_q[N-1:0]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        case (state_q)
            IDLE: begin
                // in_ready is high exactly in IDLE, so in_valid alone is the handshake
                if (bus.in_valid) begin
                    a_sh_d  = bus.a;
`ifdef MP_ADD_SUB_EN
                    b_sh_d  = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.c_in;
`else
                    b_sh_d  = bus.b;
                    carry_d = bus.c_in;
`endif
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Chunk sums enter at the MSB end; after K shifts chunk 0 sits at bit 0
                sum_d   = (sum_q >> N) | (W'(slice_s) << (W - N));
                carry_d = slice_co;
                a_sh_d  = a_sh_q >> N;
                b_sh_d  = b_sh_q >> N;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(K - 1))
                    state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.c_out     = carry_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// tb_mp_add_seq: directed bench for mp_add_seq (N=8,K=4 main instance, N=16,K=1 side instance).
module tb_mp_add_seq;
    localparam int N = 8;
    localparam int K = 4;
    localparam int W = N * K;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mp_add_seq_if #(.N(N), .K(K)) bus ();
    mp_add_seq_if #(.N(16), .K(1)) bus1 ();

    mp_add_seq #(.N(N), .K(K)) dut (.clk(clk), .rst(rst), .bus(bus));
    mp_add_seq #(.N(16), .K(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int pass_cnt = 0;
    int tot_cnt  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference: plain wide arithmetic, {c_out,sum}
    function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic sb);
        if (sb) return {(a >= b), a - b};
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    // Behavioural model: busy from accept until result consumed, result ready K edges after accept
    bit         m_init = 0, m_busy = 0, m_done = 0, m_rstate = 0;
    int         m_cnt = 0;
    logic [W:0] m_res = '0;
    logic       sub_drv = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_init = 1; m_busy = 0; m_done = 0; m_rstate = 1; m_res = '0;
        end else if (!m_busy) begin
            if (bus.in_valid) begin
                m_busy = 1; m_done = 0; m_rstate = 0; m_cnt = K;
                m_res = ref_op(bus.a, bus.b, bus.c_in, sub_drv);
            end
        end else if (!m_done) begin
            m_cnt--;
            if (m_cnt == 0) m_done = 1;
        end else if (bus.out_ready) begin
            m_busy = 0; m_done = 0;
        end
    end

    always @(negedge clk) begin
        if (m_init && !rst) begin
            chk("in_ready", {63'd0, bus.in_ready}, {63'd0, !m_busy});
            chk("out_valid", {63'd0, bus.out_valid}, {63'd0, m_done});
            if (m_done || m_rstate) begin
                chk("sum", {32'd0, bus.sum}, {32'd0, m_res[W-1:0]});
                chk("c_out", {63'd0, bus.c_out}, {63'd0, m_res[W]});
            end
        end
    end

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                            input logic sb);
        bit ok = 0;
        bus.a = a; bus.b = b; bus.c_in = cin; sub_drv = sb;
`ifdef MP_ADD_SUB_EN
        bus.sub = sb;
`endif
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            tot_cnt++;
            $display("FAIL accept_timeout: in_ready never seen, expected within 20 cycles");
        end
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (!bus.out_valid && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        if (!bus.out_valid) begin
            tot_cnt++;
            $display("FAIL done_timeout: out_valid low after %0d cycles, expected high", edges);
        end
    endtask

    task automatic finish_op();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int e;
        bus.in_valid = 0; bus.a = '0; bus.b = '0; bus.c_in = 0; bus.out_ready = 0;
        bus1.in_valid = 0; bus1.a = '0; bus1.b = '0; bus1.c_in = 0; bus1.out_ready = 0;
`ifdef MP_ADD_SUB_EN
        bus.sub = 0; bus1.sub = 0;
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_sum", {32'd0, bus.sum}, 64'd0);

        // basic add and latency
        @(posedge clk); #1;
        start_op(32'h0000_1234, 32'h0000_0001, 1'b0, 1'b0);
        wait_done(e);
        chk("basic_latency", 64'(e + 1), 64'd5);
        chk("basic_sum", {32'd0, bus.sum}, 64'h1235);
        chk("basic_c_out", {63'd0, bus.c_out}, 64'd0);
        finish_op();

        // carry ripples through every chunk
        start_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        wait_done(e);
        chk("ripple_sum", {32'd0, bus.sum}, 64'h0);
        chk("ripple_c_out", {63'd0, bus.c_out}, 64'd1);
        finish_op();

        // backpressure with a competing request held during DONE
        start_op(32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0);
        wait_done(e);
        bus.a = 32'h10; bus.b = 32'h20; bus.c_in = 0; sub_drv = 0; bus.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("bp_sum", {32'd0, bus.sum}, 64'h300);
            chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
        end
        finish_op();
        chk("bp_release_in_ready", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_done(e);
        chk("bp_next_sum", {32'd0, bus.sum}, 64'h30);
        finish_op();

        // reset during the second RUN cycle
        start_op(32'h0000_AAAA, 32'h0000_5555, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("mid_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("mid_rst_sum", {32'd0, bus.sum}, 64'd0);
        chk("mid_rst_c_out", {63'd0, bus.c_out}, 64'd0);
        start_op(32'd3, 32'd4, 1'b0, 1'b0);
        wait_done(e);
        chk("post_rst_sum", {32'd0, bus.sum}, 64'd7);
        finish_op();

`ifdef MP_ADD_SUB_EN
        start_op(32'd5, 32'd7, 1'b0, 1'b1);
        wait_done(e);
        chk("sub_neg_sum", {32'd0, bus.sum}, 64'hFFFF_FFFE);
        chk("sub_neg_c_out", {63'd0, bus.c_out}, 64'd0);
        finish_op();
        start_op(32'd7, 32'd5, 1'b1, 1'b1);
        wait_done(e);
        chk("sub_pos_sum", {32'd0, bus.sum}, 64'd2);
        chk("sub_pos_c_out", {63'd0, bus.c_out}, 64'd1);
        finish_op();
        sub_drv = 0; bus.sub = 0;
`endif

        // single-chunk instance: N=16, K=1
        begin
            bit ok = 0;
            int ed = 0;
            bus1.a = 16'hFFFF; bus1.b = 16'h0001; bus1.c_in = 0; bus1.in_valid = 1'b1;
            for (int i = 0; i < 20 && !ok; i++) begin
                @(negedge clk);
                if (bus1.in_ready) ok = 1;
                @(posedge clk); #1;
            end
            bus1.in_valid = 1'b0;
            chk("k1_accepted", {63'd0, ok}, 64'd1);
            while (!bus1.out_valid && ed < 20) begin
                @(posedge clk); #1;
                ed++;
            end
            chk("k1_latency", 64'(ed + 1), 64'd2);
            chk("k1_sum", {48'd0, bus1.sum}, 64'h0);
            chk("k1_c_out", {63'd0, bus1.c_out}, 64'd1);
            bus1.out_ready = 1'b1;
            @(posedge clk); #1;
            bus1.out_ready = 1'b0;
            chk("k1_back_idle", {63'd0, bus1.in_ready}, 64'd1);
        end

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running, expected summary by 200000");
        $fatal(1, "timeout");
    end
endmodule
